mem_access_stage: RTL and testbench

- Memory-access pipeline stage between the ALU stage and the writeback unit of the 32-bit RISC-V core.
- Takes the registered EX result, performs RV32I loads and stores against the data RAM over a req/gnt/rvalid handshake, and presents a registered result to writeback.
- Non-memory ops pass through with one cycle of latency.
- Stalls upstream while a memory transaction is outstanding.

---
 rtl/mem_access_stage.sv | 188 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// RV32I memory-access stage: loads/stores over req/gnt/rvalid, registered writeback.
// Optional watchdog abort enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_funct3,
  input  logic [31:0]       ex_result,
  input  logic [31:0]       ex_store_data,
  input  logic [4:0]        ex_rd,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_result,
  output logic              misalign_err,
  output logic              bus_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] WAIT_RD = 2'd2;

  logic [1:0]  state;
  logic [4:0]  rd_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic        bus_err_q;
  logic        tmo_hit;

  logic        is_mem;
  logic        misal;
  logic [1:0]  lo;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] sh;
  logic [31:0] ld_data;

  assign stall   = (state != IDLE);
  assign mem_req = (state == REQ);
  assign lo      = ex_result[1:0];
  assign is_mem  = ex_is_load | ex_is_store;

  always_comb begin
    misal = 1'b0;
    be_n  = 4'b1111;
    wd_n  = ex_store_data;
    unique case (ex_funct3)
      3'b001, 3'b101: misal = lo[0];
      3'b010:         misal = (lo != 2'b00);
      default:        misal = 1'b0;
    endcase
    if (ex_is_store) begin
      unique case (ex_funct3[1:0])
        2'b00: begin
          be_n = 4'b0001 << lo;
          wd_n = {4{ex_store_data[7:0]}};
        end
        2'b01: begin
          be_n = 4'b0011 << lo;
          wd_n = {2{ex_store_data[15:0]}};
        end
        default: begin
          be_n = 4'b1111;
          wd_n = ex_store_data;
        end
      endcase
    end
  end

  // Move the addressed lane down to bit 0, then extend by access type.
  always_comb begin
    sh = mem_rdata >> {lane_q, 3'b000};
    unique case (f3_q)
      3'b000:  ld_data = {{24{sh[7]}}, sh[7:0]};
      3'b100:  ld_data = {24'd0, sh[7:0]};
      3'b001:  ld_data = {{16{sh[15]}}, sh[15:0]};
      3'b101:  ld_data = {16'd0, sh[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || (state == REQ && mem_gnt)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  assign tmo_hit = (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign bus_err = bus_err_q;
`else
  assign tmo_hit = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_result    <= '0;
      misalign_err <= 1'b0;
      bus_err_q    <= 1'b0;
      rd_q         <= '0;
      f3_q         <= '0;
      lane_q       <= '0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      bus_err_q    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ex_valid) begin
            if (!is_mem) begin
              wb_valid  <= 1'b1;
              wb_rd     <= ex_rd;
              wb_result <= ex_result;
            end else if (misal) begin
              misalign_err <= 1'b1;
            end else begin
              state     <= REQ;
              mem_we    <= ex_is_store;
              mem_addr  <= ex_result[ADDR_W-1:2];
              mem_be    <= be_n;
              mem_wdata <= wd_n;
              rd_q      <= ex_rd;
              f3_q      <= ex_funct3;
              lane_q    <= lo;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            if (mem_we) begin
              state <= IDLE;
            end else if (mem_rvalid) begin
              state     <= IDLE;
              wb_valid  <= 1'b1;
              wb_rd     <= rd_q;
              wb_result <= ld_data;
            end else begin
              state <= WAIT_RD;
            end
          end else if (tmo_hit) begin
            state     <= IDLE;
            bus_err_q <= 1'b1;
          end
        end
        WAIT_RD: begin
          if (mem_rvalid) begin
            state     <= IDLE;
            wb_valid  <= 1'b1;
            wb_rd     <= rd_q;
            wb_result <= ld_data;
          end else if (tmo_hit) begin
            state     <= IDLE;
            bus_err_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage.
// Timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        stall, mem_req, mem_we;
  logic [13:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        misalign_err, bus_err;

  int errors = 0;
  int checks = 0;
  logic [36:0] exp_q[$];

  mem_access_stage #(.ADDR_W(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_funct3(ex_funct3),
    .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_result(wb_result), .misalign_err(misalign_err),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every writeback must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n && wb_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: rd=%0d res=0x%08h",
                 wb_rd, wb_result);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({wb_rd, wb_result} !== e) begin
          errors++;
          $display("FAIL wb_data: got rd=%0d 0x%08h want rd=%0d 0x%08h",
                   wb_rd, wb_result, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st,
                       input logic [2:0] f3,
                       input logic [31:0] res,
                       input logic [31:0] sd,
                       input logic [4:0] rd);
    ex_valid      = 1'b1;
    ex_is_load    = ld;
    ex_is_store   = st;
    ex_funct3     = f3;
    ex_result     = res;
    ex_store_data = sd;
    ex_rd         = rd;
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic load_slow(input logic [2:0] f3,
                           input logic [31:0] addr,
                           input logic [4:0] rd,
                           input logic [31:0] exp);
    exp_q.push_back({rd, exp});
    issue(1'b1, 1'b0, f3, addr, 32'h0, rd);
    chk("ld_be", {28'd0, mem_be}, 32'hF);
    chk("ld_we", {31'd0, mem_we}, 32'h0);
    repeat (2) begin
      tick();
      chk("ld_stall_req", {31'd0, stall}, 32'h1);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    repeat (2) begin
      chk("ld_stall_wait", {31'd0, stall}, 32'h1);
      tick();
    end
    chk("ld_stall_rv", {31'd0, stall}, 32'h1);
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("ld_stall_done", {31'd0, stall}, 32'h0);
    chk("ld_wb_valid", {31'd0, wb_valid}, 32'h1);
    tick();
    chk("ld_wb_once", {31'd0, wb_valid}, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    ex_valid = 0; ex_is_load = 0; ex_is_store = 0;
    ex_funct3 = 0; ex_result = 0; ex_store_data = 0; ex_rd = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 32'h80FF7F01;
    repeat (2) tick();
    chk("rst_stall", {31'd0, stall}, 32'h0);
    chk("rst_req", {31'd0, mem_req}, 32'h0);
    chk("rst_wb", {31'd0, wb_valid}, 32'h0);
    chk("rst_be", {28'd0, mem_be}, 32'h0);
    chk("rst_buserr", {31'd0, bus_err}, 32'h0);
    reset_n = 1'b1;
    tick();

    // Reset while waiting for read data.
    mem_gnt = 1'b1;
    issue(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 5'd5);
    chk("rm_req", {31'd0, mem_req}, 32'h1);
    tick();
    mem_gnt = 1'b0;
    chk("rm_waitrd", {31'd0, stall}, 32'h1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rm_stall", {31'd0, stall}, 32'h0);
    chk("rm_req0", {31'd0, mem_req}, 32'h0);
    chk("rm_wb", {31'd0, wb_valid}, 32'h0);
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("rm_late_rv", {31'd0, wb_valid}, 32'h0);
    tick();
    chk("rm_late_rv2", {31'd0, wb_valid}, 32'h0);

    // Back-to-back pass-through ops.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({5'(i + 1), 32'(8'h11 * (i + 1))});
      ex_valid = 1'b1; ex_is_load = 0; ex_is_store = 0;
      ex_rd = 5'(i + 1);
      ex_result = 32'(8'h11 * (i + 1));
      @(negedge clk);
      chk("pt_stall", {31'd0, stall}, 32'h0);
      if (i > 0) chk("pt_wb_seq", {31'd0, wb_valid}, 32'h1);
      tick();
    end
    ex_valid = 1'b0;
    @(negedge clk);
    chk("pt_wb_last", {31'd0, wb_valid}, 32'h1);
    tick();

    // Store lanes.
    issue(1'b0, 1'b1, 3'b000, 32'h3, 32'hAB, 5'd0);
    chk("sb_req", {31'd0, mem_req}, 32'h1);
    chk("sb_we", {31'd0, mem_we}, 32'h1);
    chk("sb_be", {28'd0, mem_be}, 32'h8);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    chk("sb_addr", {18'd0, mem_addr}, 32'h0);
    tick();
    chk("sb_hold", {27'd0, mem_req, mem_be}, 32'h18);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("sb_done", {30'd0, stall, mem_req}, 32'h0);
    issue(1'b0, 1'b1, 3'b001, 32'h6, 32'h1234, 5'd0);
    chk("sh_be", {28'd0, mem_be}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'h12341234);
    chk("sh_addr", {18'd0, mem_addr}, 32'h1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("sh_done", {30'd0, stall, mem_req}, 32'h0);
    tick();

    // Load extension with delayed handshake.
    load_slow(3'b000, 32'h2, 5'd7, 32'hFFFFFFFF);
    load_slow(3'b100, 32'h3, 5'd8, 32'h00000080);
    load_slow(3'b001, 32'h2, 5'd9, 32'hFFFF80FF);
    load_slow(3'b010, 32'h0, 5'd10, 32'h80FF7F01);

    // Minimum latency, gnt and rvalid in the same cycle, rd=0.
    exp_q.push_back({5'd0, 32'h00007F01});
    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    issue(1'b1, 1'b0, 3'b101, 32'h0, 32'h0, 5'd0);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("fast_wb", {31'd0, wb_valid}, 32'h1);
    chk("fast_stall", {31'd0, stall}, 32'h0);
    tick();

    // Misaligned word load.
    issue(1'b1, 1'b0, 3'b010, 32'h2, 32'h0, 5'd4);
    chk("mis_err", {31'd0, misalign_err}, 32'h1);
    chk("mis_req", {31'd0, mem_req}, 32'h0);
    chk("mis_stall", {31'd0, stall}, 32'h0);
    chk("mis_wb", {31'd0, wb_valid}, 32'h0);
    tick();
    chk("mis_pulse", {31'd0, misalign_err}, 32'h0);

`ifdef MEM_TIMEOUT_EN
    begin
      int n;
      n = 0;
      issue(1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 5'd3);
      @(negedge clk);
      while (mem_req && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("tmo_cycles", 32'(n), 32'd8);
      chk("tmo_buserr", {31'd0, bus_err}, 32'h1);
      chk("tmo_stall", {31'd0, stall}, 32'h0);
      tick();
      chk("tmo_pulse", {31'd0, bus_err}, 32'h0);
    end
`endif

    repeat (3) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
